// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between NREQ requesters.
// Requests are arbitrated, their operands are registered onto alu_a/alu_b/alu_sel,
// and the ALU result is captured for one valid/ready response tagged with rsp_id.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_a/req_b/req_sel
// (per-requester slices); rsp_valid/rsp_ready/rsp_id/rsp_out/rsp_c (response);
// alu_a/alu_b/alu_sel/alu_out/alu_c (external ALU); busy (FSM not idle).
// ALU_ARB_FIXED_PRIO_EN: lowest index always wins; otherwise round-robin.
module alu_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [W-1:0]      rsp_out,
  output logic              rsp_c,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [1:0]        alu_sel,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_c,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next_state;
  logic [1:0] gnt;
  logic any;
  logic accept;
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'd0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[k]) begin
        gnt = 2'(k);
        any = 1'b1;
      end
  end
`else
  logic [1:0] rr;
  always_comb begin
    gnt = 2'd0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!any && req_valid[(int'(rr) + k) % NREQ]) begin
        gnt = 2'((int'(rr) + k) % NREQ);
        any = 1'b1;
      end
  end
  always_ff @(posedge clk)
    if (rst) rr <= 2'd0;
    else if (accept) rr <= (gnt == 2'(NREQ - 1)) ? 2'd0 : gnt + 2'd1;
`endif
  // Nothing is accepted while reset is held, so a request survives reset untouched.
  assign accept = (state == IDLE) && any && !rst;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = (state == IDLE) ? (any ? EXEC : IDLE) :
                 (state == EXEC) ? RESP :
                 (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = accept ? {{(NREQ-1){1'b0}}, 1'b1} << gnt : '0;
    rsp_valid = state == RESP;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= 2'd0;
      rsp_id  <= 2'd0;
      rsp_out <= '0;
      rsp_c   <= 1'b0;
    end else if (accept) begin
      alu_a   <= req_a[int'(gnt)*W +: W];
      alu_b   <= req_b[int'(gnt)*W +: W];
      alu_sel <= req_sel[int'(gnt)*2 +: 2];
      rsp_id  <= gnt;
    end else if (state == EXEC) begin
      rsp_out <= alu_out;
      rsp_c   <= alu_c;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;
  localparam int W = 4;
  localparam int NREQ = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ*2-1:0] req_sel = '0;
  logic rsp_valid, rsp_c, alu_c, busy;
  logic rsp_ready = 1'b0;
  logic [1:0] rsp_id, alu_sel;
  logic [W-1:0] rsp_out, alu_a, alu_b, alu_out;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [NREQ-1:0] acc = '0;
  int ids[$];
  int ph = 0;
  int m_rr = 0;
  int m_id = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_out = '0;
  logic [1:0] m_sel = '0;
  logic m_c = 1'b0;

  alu_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_c(rsp_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_c(alu_c), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] s);
    case (s)
      2'd0: return {1'b0, a} + {1'b0, b};
      2'd1: return {1'b0, a} - {1'b0, b};
      2'd2: return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_c, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

  function automatic int pick(logic [NREQ-1:0] v, int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transaction-level reference: ph counts how far the current op has progressed
  // (0 none, 1 operands issued, 2 result waiting for the consumer).
  always @(negedge clk) begin : cmp
    int g;
    g = pick(req_valid, m_rr);
    if (cyc > 0) begin
      check("req_ready", int'(req_ready), (ph == 0 && !rst && g >= 0) ? (1 << g) : 0);
      check("rsp_valid", int'(rsp_valid), int'(ph == 2));
      check("busy", int'(busy), int'(ph != 0));
      check("alu_a", int'(alu_a), int'(m_a));
      check("alu_b", int'(alu_b), int'(m_b));
      check("alu_sel", int'(alu_sel), int'(m_sel));
      check("rsp_id", int'(rsp_id), m_id);
      check("rsp_out", int'(rsp_out), int'(m_out));
      check("rsp_c", int'(rsp_c), int'(m_c));
    end
    acc = req_ready;
    if (rsp_valid && rsp_ready && !rst) ids.push_back(int'(rsp_id));
    if (rst) begin
      ph = 0; m_rr = 0; m_id = 0; m_a = '0; m_b = '0; m_sel = '0; m_out = '0; m_c = 1'b0;
    end else if (ph == 0) begin
      if (g >= 0) begin
        m_a = req_a[g*W +: W];
        m_b = req_b[g*W +: W];
        m_sel = req_sel[g*2 +: 2];
        m_id = g;
`ifndef ALU_ARB_FIXED_PRIO_EN
        m_rr = (g + 1) % NREQ;
`endif
        ph = 1;
      end
    end else if (ph == 1) begin
      {m_c, m_out} = alu_ref(m_a, m_b, m_sel);
      ph = 2;
    end else if (rsp_ready) ph = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(string name);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(name, int'(rsp_valid), 1);
  endtask

  initial begin
    int exp_ids[4];
    logic [W:0] r;
    logic [W-1:0] sa, sb;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_rsp_out", int'(rsp_out), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_a[3:0] = 4'd6;
    req_b[3:0] = 4'd2;
    req_sel[1:0] = 2'd0;
    @(negedge clk);
    check("single_ready", int'(req_ready), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_alu_a", int'(alu_a), 6);
    check("single_alu_b", int'(alu_b), 2);
    tick();
    @(negedge clk);
    check("single_rsp_valid", int'(rsp_valid), 1);
    check("single_rsp_id", int'(rsp_id), 0);
    check("single_rsp_out", int'(rsp_out), 8);
    check("single_rsp_c", int'(rsp_c), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ids.delete();
    req_valid = 2'b11;
    req_a = 8'h53;
    req_b = 8'h21;
    req_sel = 4'b0110;
    repeat (12) tick();
    req_valid = '0;
    check("cont_count", ids.size(), 4);
    for (int i = 0; i < 4 && i < ids.size(); i++) check("cont_order", ids[i], exp_ids[i]);
    repeat (3) tick();
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    req_a[7:4] = 4'd9;
    req_b[7:4] = 4'd9;
    req_sel[3:2] = 2'd0;
    tick();
    req_valid = 2'b01;
    wait_rsp("bp_timeout");
    check("bp_rsp_out", int'(rsp_out), 2);
    check("bp_rsp_c", int'(rsp_c), 1);
    check("bp_rsp_id", int'(rsp_id), 1);
    repeat (5) begin
      check("bp_hold_valid", int'(rsp_valid), 1);
      check("bp_hold_out", int'(rsp_out), 2);
      check("bp_hold_ready", int'(req_ready), 0);
      check("bp_hold_busy", int'(busy), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_release_busy", int'(busy), 0);
    check("bp_release_valid", int'(rsp_valid), 0);
    check("bp_release_ready", int'(req_ready), 1);
    tick();
    req_valid = '0;
    repeat (4) tick();
    req_valid = 2'b01;
    req_a[3:0] = 4'd3;
    req_b[3:0] = 4'd4;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(rsp_valid), 0);
    check("mid_rst_grant", int'(req_ready), 1);
    tick();
    req_valid = 2'b10;
    wait_rsp("mid_rst_timeout");
    check("mid_rst_id", int'(rsp_id), 0);
    tick();
    @(negedge clk);
    check("mid_rst_next", int'(req_ready), 2);
    tick();
    req_valid = '0;
    repeat (4) tick();
    for (int s = 0; s < 4; s++) begin
      sa = 4'($urandom);
      sb = 4'($urandom);
      r = alu_ref(sa, sb, 2'(s));
      req_a[7:4] = sa;
      req_b[7:4] = sb;
      req_sel[3:2] = 2'(s);
      req_valid = 2'b10;
      tick();
      req_valid = '0;
      wait_rsp("sweep_timeout");
      check("sweep_id", int'(rsp_id), 1);
      check("sweep_out", int'(rsp_out), int'(r[W-1:0]));
      check("sweep_c", int'(rsp_c), int'(r[W]));
      tick();
    end
    for (int n = 0; n < 600; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = 1'($urandom);
          req_a[i*W +: W] = W'($urandom);
          req_b[i*W +: W] = W'($urandom);
          req_sel[i*2 +: 2] = 2'($urandom);
        end
      rsp_ready = ($urandom % 4) != 0;
      rst = ($urandom % 60) == 0;
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
